// File: rtl/ext_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ext_interrupt_arbiter
// Brief    : Gathers level-sensitive device interrupt lines through per-source
//            gateways. It applies per-source priority, an enable mask and a
//            global threshold, then presents the winning code to the CSR unit
//            and tracks the claim/complete handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ext_interrupt_arbiter #(
    parameter int NUM_SOURCES = 8,
    parameter int PRIO_WIDTH  = 3,
    parameter int CODE_WIDTH  = $clog2(NUM_SOURCES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] srcLevel,
    input  logic                   prioWE,
    input  logic [CODE_WIDTH-1:0]  prioIndex,
    input  logic [PRIO_WIDTH-1:0]  prioData,
    input  logic                   enableWE,
    input  logic [NUM_SOURCES-1:0] enableData,
    input  logic                   thresholdWE,
    input  logic [PRIO_WIDTH-1:0]  thresholdData,
    input  logic                   claimReq,
    output logic [CODE_WIDTH-1:0]  claimCode,
    input  logic                   completeReq,
    input  logic [CODE_WIDTH-1:0]  completeCode,
    output logic                   reqExternalInterrupt,
    output logic [CODE_WIDTH-1:0]  externalInterruptCode,
    output logic [NUM_SOURCES-1:0] pendingOut,
    output logic [NUM_SOURCES-1:0] inFlightOut
);

    logic [NUM_SOURCES-1:0] r_pending;
    logic [NUM_SOURCES-1:0] r_inFlight;
    logic [NUM_SOURCES-1:0] r_enable;
    logic [PRIO_WIDTH-1:0]  r_threshold;
    logic [PRIO_WIDTH-1:0]  r_prio [NUM_SOURCES];
    logic                   r_req;
    logic [CODE_WIDTH-1:0]  r_code;

    logic [NUM_SOURCES-1:0] w_pendingNext;
    logic [NUM_SOURCES-1:0] w_inFlightNext;
    logic [NUM_SOURCES-1:0] w_enableNext;
    logic [PRIO_WIDTH-1:0]  w_thresholdNext;
    logic [PRIO_WIDTH-1:0]  w_prioNext [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] w_claimed;
    logic [NUM_SOURCES-1:0] w_completed;
    logic                   w_claimValid;
    logic [PRIO_WIDTH-1:0]  w_bestPrio;
    logic [CODE_WIDTH-1:0]  w_bestCode;

    // A claim only acts when a winner is actually being presented
    assign w_claimValid = claimReq && (r_code != '0);

    // Gateway, handshake and configuration next-state values for every source
    always_comb begin
        w_claimed       = '0;
        w_completed     = '0;
        w_pendingNext   = r_pending;
        w_inFlightNext  = r_inFlight;
        w_enableNext    = enableWE ? enableData : r_enable;
        w_thresholdNext = thresholdWE ? thresholdData : r_threshold;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            w_claimed[i]   = w_claimValid && (r_code == CODE_WIDTH'(i + 1));
            w_completed[i] = completeReq && (completeCode == CODE_WIDTH'(i + 1))
                             && r_inFlight[i];
            // Levels are ignored while in flight; a claim clears the latch
            w_pendingNext[i] = w_claimed[i] ? 1'b0
                             : (r_pending[i] | (srcLevel[i] & ~r_inFlight[i] & ~r_pending[i]));
            // Claim wins over a same-cycle completion of the same source
            w_inFlightNext[i] = w_claimed[i] | (r_inFlight[i] & ~w_completed[i]);
            w_prioNext[i]     = (prioWE && (prioIndex == CODE_WIDTH'(i + 1)))
                              ? prioData : r_prio[i];
        end
    end

    // Arbitrate over next-state values: highest priority, lowest code on ties
    always_comb begin
        w_bestPrio = '0;
        w_bestCode = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (w_pendingNext[i] && w_enableNext[i] &&
                (w_prioNext[i] > w_thresholdNext) && (w_prioNext[i] > w_bestPrio)) begin
                w_bestPrio = w_prioNext[i];
                w_bestCode = CODE_WIDTH'(i + 1);
            end
        end
    end

    // State and registered arbitration result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_inFlight  <= '0;
            r_enable    <= '0;
            r_threshold <= '0;
            r_req       <= 1'b0;
            r_code      <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                r_prio[i] <= '0;
            end
        end else begin
            r_pending   <= w_pendingNext;
            r_inFlight  <= w_inFlightNext;
            r_enable    <= w_enableNext;
            r_threshold <= w_thresholdNext;
            r_req       <= (w_bestCode != '0);
            r_code      <= w_bestCode;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                r_prio[i] <= w_prioNext[i];
            end
        end
    end

    assign claimCode             = claimReq ? r_code : '0;
    assign reqExternalInterrupt  = r_req;
    assign externalInterruptCode = r_code;
    assign pendingOut            = r_pending;
    assign inFlightOut           = r_inFlight;

endmodule
`default_nettype wire

// File: tb/tb_ext_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_interrupt_arbiter
// Brief    : Directed self-checking bench for ext_interrupt_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_interrupt_arbiter;

    localparam int NUM_SOURCES = 8;
    localparam int PRIO_WIDTH  = 3;
    localparam int CODE_WIDTH  = 4;

    logic                   clk;
    logic                   rst;
    logic [NUM_SOURCES-1:0] srcLevel;
    logic                   prioWE;
    logic [CODE_WIDTH-1:0]  prioIndex;
    logic [PRIO_WIDTH-1:0]  prioData;
    logic                   enableWE;
    logic [NUM_SOURCES-1:0] enableData;
    logic                   thresholdWE;
    logic [PRIO_WIDTH-1:0]  thresholdData;
    logic                   claimReq;
    logic [CODE_WIDTH-1:0]  claimCode;
    logic                   completeReq;
    logic [CODE_WIDTH-1:0]  completeCode;
    logic                   reqExternalInterrupt;
    logic [CODE_WIDTH-1:0]  externalInterruptCode;
    logic [NUM_SOURCES-1:0] pendingOut;
    logic [NUM_SOURCES-1:0] inFlightOut;

    int compared   = 0;
    int mismatched = 0;

    ext_interrupt_arbiter #(
        .NUM_SOURCES(NUM_SOURCES),
        .PRIO_WIDTH (PRIO_WIDTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .srcLevel             (srcLevel),
        .prioWE               (prioWE),
        .prioIndex            (prioIndex),
        .prioData             (prioData),
        .enableWE             (enableWE),
        .enableData           (enableData),
        .thresholdWE          (thresholdWE),
        .thresholdData        (thresholdData),
        .claimReq             (claimReq),
        .claimCode            (claimCode),
        .completeReq          (completeReq),
        .completeCode         (completeCode),
        .reqExternalInterrupt (reqExternalInterrupt),
        .externalInterruptCode(externalInterruptCode),
        .pendingOut           (pendingOut),
        .inFlightOut          (inFlightOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearStrobes();
        prioWE      = 1'b0;
        enableWE    = 1'b0;
        thresholdWE = 1'b0;
        claimReq    = 1'b0;
        completeReq = 1'b0;
    endtask

    task automatic writePrio(input int code, input int prio);
        prioWE    = 1'b1;
        prioIndex = CODE_WIDTH'(code);
        prioData  = PRIO_WIDTH'(prio);
        tick();
        prioWE    = 1'b0;
    endtask

    task automatic doClaim();
        claimReq = 1'b1;
        tick();
        claimReq = 1'b0;
    endtask

    task automatic doComplete(input int code);
        completeReq  = 1'b1;
        completeCode = CODE_WIDTH'(code);
        tick();
        completeReq  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        srcLevel = '0;
        prioIndex = '0;
        prioData = '0;
        enableData = '0;
        thresholdData = '0;
        completeCode = '0;
        clearStrobes();
        tick();
        check("rst_req", 32'(reqExternalInterrupt), 32'd0);
        check("rst_code", 32'(externalInterruptCode), 32'd0);
        check("rst_pending", 32'(pendingOut), 32'h00);
        check("rst_inflight", 32'(inFlightOut), 32'h00);
        rst = 1'b0;

        // Simultaneous config writes plus a one-cycle pulse on source code 3
        enableWE = 1'b1; enableData = 8'hFF;
        prioWE = 1'b1; prioIndex = 4'd3; prioData = 3'd2;
        thresholdWE = 1'b1; thresholdData = 3'd0;
        srcLevel = 8'h04;
        tick();
        clearStrobes();
        srcLevel = 8'h00;
        check("pulse_req", 32'(reqExternalInterrupt), 32'd1);
        check("pulse_code", 32'(externalInterruptCode), 32'd3);
        check("pulse_pending", 32'(pendingOut), 32'h04);
        tick();
        check("pulse_hold_pending", 32'(pendingOut), 32'h04);
        check("pulse_hold_code", 32'(externalInterruptCode), 32'd3);
        claimReq = 1'b1;
        #1;
        check("claim3_code", 32'(claimCode), 32'd3);
        tick();
        claimReq = 1'b0;
        check("claim3_inflight", 32'(inFlightOut), 32'h04);
        check("claim3_pending", 32'(pendingOut), 32'h00);
        check("claim3_req", 32'(reqExternalInterrupt), 32'd0);
        doComplete(3);
        check("complete3_inflight", 32'(inFlightOut), 32'h00);

        // Equal priorities: lowest code wins, claim moves on to the next
        writePrio(2, 4);
        writePrio(5, 4);
        srcLevel = 8'h12;
        tick();
        srcLevel = 8'h00;
        check("tie_code", 32'(externalInterruptCode), 32'd2);
        check("tie_pending", 32'(pendingOut), 32'h12);
        claimReq = 1'b1;
        #1;
        check("tie_claimcode", 32'(claimCode), 32'd2);
        tick();
        claimReq = 1'b0;
        check("tie_next_code", 32'(externalInterruptCode), 32'd5);
        check("tie_inflight", 32'(inFlightOut), 32'h02);
        check("tie_pending_after", 32'(pendingOut), 32'h10);
        doClaim();
        check("claim5_code", 32'(externalInterruptCode), 32'd0);
        doComplete(2);
        doComplete(5);
        check("cleanup_inflight", 32'(inFlightOut), 32'h00);

        // Threshold is a strict comparison
        writePrio(4, 3);
        srcLevel = 8'h08;
        tick();
        srcLevel = 8'h00;
        check("thr_code_before", 32'(externalInterruptCode), 32'd4);
        thresholdWE = 1'b1; thresholdData = 3'd3;
        tick();
        thresholdWE = 1'b0;
        check("thr_eq_req", 32'(reqExternalInterrupt), 32'd0);
        check("thr_eq_code", 32'(externalInterruptCode), 32'd0);
        check("thr_eq_pending", 32'(pendingOut), 32'h08);
        thresholdWE = 1'b1; thresholdData = 3'd2;
        tick();
        thresholdWE = 1'b0;
        check("thr_low_req", 32'(reqExternalInterrupt), 32'd1);
        check("thr_low_code", 32'(externalInterruptCode), 32'd4);
        doClaim();
        doComplete(4);

        // Level held high across claim/complete re-triggers only after complete
        writePrio(1, 5);
        srcLevel = 8'h01;
        tick();
        check("lvl_code", 32'(externalInterruptCode), 32'd1);
        doClaim();
        check("lvl_inflight", 32'(inFlightOut), 32'h01);
        tick();
        check("lvl_no_repend", 32'(pendingOut), 32'h00);
        check("lvl_no_req", 32'(reqExternalInterrupt), 32'd0);
        doComplete(1);
        check("lvl_cmp_inflight", 32'(inFlightOut), 32'h00);
        check("lvl_cmp_pending", 32'(pendingOut), 32'h00);
        tick();
        check("lvl_repend", 32'(pendingOut), 32'h01);
        check("lvl_rereq", 32'(reqExternalInterrupt), 32'd1);
        check("lvl_recode", 32'(externalInterruptCode), 32'd1);
        srcLevel = 8'h00;
        doClaim();
        doComplete(1);

        // Claim with nothing to grant, stray complete, same-cycle claim+complete
        claimReq = 1'b1;
        #1;
        check("noclaim_code", 32'(claimCode), 32'd0);
        tick();
        claimReq = 1'b0;
        check("noclaim_pending", 32'(pendingOut), 32'h00);
        check("noclaim_inflight", 32'(inFlightOut), 32'h00);
        doComplete(6);
        check("stray_complete", 32'(inFlightOut), 32'h00);
        thresholdWE = 1'b1; thresholdData = 3'd1;
        tick();
        thresholdWE = 1'b0;
        srcLevel = 8'h04;
        tick();
        srcLevel = 8'h00;
        check("cc_code", 32'(externalInterruptCode), 32'd3);
        claimReq = 1'b1;
        completeReq = 1'b1; completeCode = 4'd3;
        tick();
        clearStrobes();
        check("cc_inflight", 32'(inFlightOut), 32'h04);
        check("cc_pending", 32'(pendingOut), 32'h00);
        doComplete(3);

        // Reset while busy clears everything, including priorities
        srcLevel = 8'h08;
        tick();
        srcLevel = 8'h00;
        doClaim();
        srcLevel = 8'h42;
        tick();
        srcLevel = 8'h00;
        check("busy_pending", 32'(pendingOut), 32'h42);
        check("busy_inflight", 32'(inFlightOut), 32'h08);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_pending", 32'(pendingOut), 32'h00);
        check("rst2_inflight", 32'(inFlightOut), 32'h00);
        check("rst2_req", 32'(reqExternalInterrupt), 32'd0);
        check("rst2_code", 32'(externalInterruptCode), 32'd0);
        enableWE = 1'b1; enableData = 8'hFF;
        srcLevel = 8'hFF;
        tick();
        enableWE = 1'b0;
        srcLevel = 8'h00;
        check("rst2_all_pending", 32'(pendingOut), 32'hFF);
        check("rst2_prio_zero_req", 32'(reqExternalInterrupt), 32'd0);
        check("rst2_prio_zero_code", 32'(externalInterruptCode), 32'd0);

        // Disabled pending source becomes eligible once enabled
        writePrio(6, 7);
        enableWE = 1'b1; enableData = 8'h00;
        tick();
        enableWE = 1'b0;
        check("dis_req", 32'(reqExternalInterrupt), 32'd0);
        enableWE = 1'b1; enableData = 8'h20;
        tick();
        enableWE = 1'b0;
        check("en_code", 32'(externalInterruptCode), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
